// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with an internal synchronous-read data RAM and the MEM/WB register.
// Ports: Clock/Reset (sync, active-high); ALUResult/ALURT/WriteReg/RegWrite/MemRead/MemWrite/MemSize/MemSigned
// from EX; ALUResult_MEM forwarding copy and Stall to upstream; MisalignedErr fault pulse; *_WB MEM/WB outputs.
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALURT,
  input  logic [4:0]  WriteReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] ALUResult_MEM,
  output logic        Stall,
  output logic        MisalignedErr,
  output logic [31:0] ReadData_WB,
  output logic [31:0] ALUResult_WB,
  output logic [4:0]  WriteReg_WB,
  output logic        RegWrite_WB,
  output logic        MemToReg_WB
);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_DATA = 1'b1;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [0:0] state_q, state_d;
  logic err_q, rw_q, rw_d, mtr_q, mtr_d;
  logic [31:0] rd_q, rd_d, alu_q;
  logic [4:0] wreg_q, wreg_d;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0] lane;
  logic fault, issue, bubble, we;
  logic [3:0] be;
  logic [31:0] wdata, shifted, ld_ext;
  logic [15:0] half;
  assign idx  = ALUResult[ADDR_BITS+1:2];
  assign lane = ALUResult[1:0];
  assign fault = (MemRead & MemWrite) | ((MemRead | MemWrite) &
                 ((MemSize == 2'b01 & lane[0]) | (MemSize == 2'b10 & |lane) | MemSize == 2'b11));
  // A read is issued only from IDLE; the LOAD_DATA cycle sees the same held inputs and must not re-issue.
  assign issue  = state_q == IDLE & MemRead & ~fault;
  assign bubble = fault | issue;
  assign we     = MemWrite & ~fault;
  assign Stall  = issue & ~Reset;
  assign ALUResult_MEM = ALUResult;
  assign be    = MemSize == 2'b00 ? 4'b0001 << lane : MemSize == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = MemSize == 2'b00 ? {4{ALURT[7:0]}} : MemSize == 2'b01 ? {2{ALURT[15:0]}} : ALURT;
  assign shifted = rdata_q >> {lane, 3'b000};
  assign half    = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign ld_ext  = MemSize == 2'b00 ? {{24{MemSigned & shifted[7]}}, shifted[7:0]} :
                   MemSize == 2'b01 ? {{16{MemSigned & half[15]}}, half} : rdata_q;
  always_comb begin
    state_d = issue ? LOAD_DATA : IDLE;
    mtr_d   = state_q == LOAD_DATA & ~bubble;
    rd_d    = mtr_d ? ld_ext : 32'd0;
    wreg_d  = bubble ? 5'd0 : WriteReg;
    rw_d    = ~bubble & ~MemWrite & RegWrite;
  end
  always_ff @(posedge Clock) begin
    for (int i = 0; i < 4; i++)
      if (we & be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
    if (issue) rdata_q <= mem_q[idx];
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      wreg_q  <= 5'd0;
      rw_q    <= 1'b0;
      mtr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= fault;
      rd_q    <= rd_d;
      alu_q   <= ALUResult;
      wreg_q  <= wreg_d;
      rw_q    <= rw_d;
      mtr_q   <= mtr_d;
    end
  end
  assign MisalignedErr = err_q;
  assign ReadData_WB   = rd_q;
  assign ALUResult_WB  = alu_q;
  assign WriteReg_WB   = wreg_q;
  assign RegWrite_WB   = rw_q;
  assign MemToReg_WB   = mtr_q;
endmodule
